// File: rtl/im_loader_if.sv
// im_loader_if: byte-stream handshake plus SRAM_wrapper-style write port.
// The master modport is the loader's view: it consumes the byte stream and
// drives the SRAM port. The slave modport is the environment's view.
interface im_loader_if #(
  parameter int ADDR_W = 14
) ();

  // Byte stream into the loader
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;

  // SRAM write port out of the loader
  logic              sram_cs;
  logic              sram_oe;
  logic [3:0]        sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [31:0]       sram_di;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output sram_cs,
    output sram_oe,
    output sram_web,
    output sram_a,
    output sram_di
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  sram_cs,
    input  sram_oe,
    input  sram_web,
    input  sram_a,
    input  sram_di
  );

endinterface

// File: rtl/im_loader.sv
// im_loader: fills the instruction memory from a byte stream.
// Every 4 accepted bytes are packed little-endian into one 32-bit word.
// Each word is written to consecutive SRAM word addresses, starting at base_addr.
// cpu_hold keeps the CPU in reset until the first image load completes.
// Optional macro IM_LOADER_CHECKSUM_EN adds a 32-bit sum of the words written.
// All outputs come straight from flops. The next values are decoded from the
// next state, so no input reaches an output combinationally.
module im_loader #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len_words,
  im_loader_if.master       bus,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold
`ifdef IM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0]  word_cnt_inc;

  logic              in_ready_q, in_ready_d;
  logic              sram_cs_q, sram_cs_d;
  logic [3:0]        sram_web_q, sram_web_d;
  logic [ADDR_W-1:0] sram_a_q, sram_a_d;
  logic [31:0]       sram_di_q, sram_di_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cpu_hold_q, cpu_hold_d;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0]       checksum_q, checksum_d;
`endif

  // Next-state logic, with the registered outputs decoded from the next state
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    cpu_hold_d   = cpu_hold_q;
    sram_di_d    = sram_di_q;
    word_cnt_inc = word_cnt_q + LEN_W'(1);
`ifdef IM_LOADER_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef IM_LOADER_CHECKSUM_EN
          checksum_d = '0;
`endif
          if (len_words != '0) begin
            state_d    = S_COLLECT;
            addr_d     = base_addr;
            len_d      = len_words;
            byte_cnt_d = '0;
            word_cnt_d = '0;
          end else begin
            // An empty image still counts as a completed load
            state_d = S_DONE;
          end
        end
      end

      S_COLLECT: begin
        // in_ready is high for the whole of COLLECT, so valid alone means a transfer
        if (bus.in_valid && in_ready_q) begin
          for (int i = 0; i < 4; i++) begin
            if (byte_cnt_q == 2'(i)) begin
              word_d[8*i +: 8] = bus.in_data;
            end
          end
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        word_cnt_d = word_cnt_inc;
`ifdef IM_LOADER_CHECKSUM_EN
        checksum_d = checksum_q + sram_di_q;
`endif
        if (word_cnt_inc == len_q) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_COLLECT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_COLLECT);
    busy_d     = (state_d == S_COLLECT) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    sram_cs_d  = (state_d == S_WRITE);
    sram_web_d = (state_d == S_WRITE) ? 4'b0000 : 4'hF;
    sram_a_d   = addr_d;
    if (state_d == S_WRITE) begin
      sram_di_d = word_d;
    end
    // The first completed load releases the CPU for good
    if (state_d == S_DONE) begin
      cpu_hold_d = 1'b0;
    end
  end

  // State and output registers; reset drops WEB to idle right away, even mid-write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      in_ready_q <= 1'b0;
      sram_cs_q  <= 1'b0;
      sram_web_q <= 4'hF;
      sram_a_q   <= '0;
      sram_di_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cpu_hold_q <= 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      in_ready_q <= in_ready_d;
      sram_cs_q  <= sram_cs_d;
      sram_web_q <= sram_web_d;
      sram_a_q   <= sram_a_d;
      sram_di_q  <= sram_di_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cpu_hold_q <= cpu_hold_d;
`ifdef IM_LOADER_CHECKSUM_EN
      checksum_q <= checksum_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.sram_cs  = sram_cs_q;
  assign bus.sram_oe  = 1'b0;         // the loader only ever writes
  assign bus.sram_web = sram_web_q;
  assign bus.sram_a   = sram_a_q;
  assign bus.sram_di  = sram_di_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cpu_hold     = cpu_hold_q;
`ifdef IM_LOADER_CHECKSUM_EN
  assign checksum     = checksum_q;
`endif

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: table-driven bench for im_loader.
// Cycle numbers in the table count from the cycle in which start is high (cycle 0).
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_im_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] len_words;
  logic        busy;
  logic        done;
  logic        cpu_hold;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  im_loader_if #(.ADDR_W(14)) bus ();

  im_loader #(.ADDR_W(14), .LEN_W(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len_words (len_words),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .cpu_hold  (cpu_hold)
`ifdef IM_LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Observed SRAM writes and done pulses
  int          wr_cyc[$];
  logic [13:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          dn_cyc[$];
  logic        dn_hold[$];
  logic        dn_busy[$];
  logic [31:0] dn_csum[$];

  always @(negedge clk) begin
    // WEB is all-low with CS high, or all-high with CS low; OE never asserts
    if (bus.sram_web === 4'b0000)
      chk("bus_legal", {bus.sram_oe, bus.sram_cs, bus.sram_web}, 6'b01_0000);
    else
      chk("bus_legal", {bus.sram_oe, bus.sram_cs, bus.sram_web}, 6'b00_1111);
    if (bus.sram_web !== 4'hF) begin
      wr_cyc.push_back(cyc);
      wr_a.push_back(bus.sram_a);
      wr_d.push_back(bus.sram_di);
    end
    if (done === 1'b1) begin
      dn_cyc.push_back(cyc);
      dn_hold.push_back(cpu_hold);
      dn_busy.push_back(busy);
`ifdef IM_LOADER_CHECKSUM_EN
      dn_csum.push_back(checksum);
`else
      dn_csum.push_back(32'h0);
`endif
    end
  end

  logic [7:0] img [8];

  typedef struct {
    string       name;
    logic [13:0] base;
    logic [14:0] len;
    bit          gap;     // in_valid toggles every other cycle
    bit          junk;    // hold a stray start high during the load
    int          n_wr;
    logic [13:0] a0, a1;
    logic [31:0] d0, d1;
    int          c0, c1;
    int          c_done;
    logic [31:0] csum;
  } vec_t;

  function automatic vec_t mk(string name, logic [13:0] base, logic [14:0] len, bit gap, bit junk,
                              int n_wr, logic [13:0] a0, logic [13:0] a1, int c0, int c1, int c_done,
                              logic [31:0] csum);
    vec_t v;
    v.name = name; v.base = base; v.len = len; v.gap = gap; v.junk = junk;
    v.n_wr = n_wr; v.a0 = a0; v.a1 = a1;
    v.d0 = 32'h0000_0013; v.d1 = 32'h0010_0093;
    v.c0 = c0; v.c1 = c1; v.c_done = c_done; v.csum = csum;
    return v;
  endfunction

  task automatic clear_logs();
    wr_cyc.delete(); wr_a.delete(); wr_d.delete();
    dn_cyc.delete(); dn_hold.delete(); dn_busy.delete(); dn_csum.delete();
  endtask

  task automatic begin_load(input logic [13:0] b, input logic [14:0] l, output int t0);
    @(negedge clk);
    clear_logs();
    start     = 1'b1;
    base_addr = b;
    len_words = l;
    t0        = cyc;
  endtask

  // Offer bytes from img until nbytes have been accepted
  task automatic feed(input int nbytes, input bit gap, input bit junk);
    int idx = 0;
    int budget = 0;
    bit tog = 1'b1;
    while (idx < nbytes && budget < 200) begin
      @(negedge clk);
      budget++;
      start = junk;
      if (junk) begin
        base_addr = 14'h0100;
        len_words = 15'd1;
      end
      bus.in_valid = gap ? tog : 1'b1;
      tog = ~tog;
      bus.in_data = img[idx % 8];
      // in_ready is registered, so its value now is what the next edge sees
      if (bus.in_valid && bus.in_ready) idx++;
    end
    chk("feed_accepted", idx, nbytes);
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    int budget;
    begin_load(v.base, v.len, t0);
    feed(4 * int'(v.len), v.gap, v.junk);
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b0;
    budget = 0;
    while (dn_cyc.size() == 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    chk({v.name, "_done_pulses"}, dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) begin
      chk({v.name, "_done_cycle"}, dn_cyc[0] - t0, v.c_done);
      chk({v.name, "_done_hold"}, dn_hold[0], 1'b0);
      chk({v.name, "_done_busy"}, dn_busy[0], 1'b0);
`ifdef IM_LOADER_CHECKSUM_EN
      chk({v.name, "_checksum"}, dn_csum[0], v.csum);
`endif
    end
    chk({v.name, "_nwrites"}, wr_a.size(), v.n_wr);
    for (int k = 0; k < v.n_wr && k < wr_a.size(); k++) begin
      chk({v.name, "_wr_addr"}, wr_a[k], (k == 0) ? v.a0 : v.a1);
      chk({v.name, "_wr_data"}, wr_d[k], (k == 0) ? v.d0 : v.d1);
      chk({v.name, "_wr_cycle"}, wr_cyc[k] - t0, (k == 0) ? v.c0 : v.c1);
    end
    chk({v.name, "_after_busy"}, busy, 1'b0);
    chk({v.name, "_after_hold"}, cpu_hold, 1'b0);
    chk({v.name, "_after_ready"}, bus.in_ready, 1'b0);
    $display("load %s: base=%h len=%0d writes=%0d done_pulses=%0d", v.name, v.base, v.len,
             wr_a.size(), dn_cyc.size());
  endtask

  vec_t vecs[5];

  initial begin
    int t0;
    img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
    img[4] = 8'h93; img[5] = 8'h00; img[6] = 8'h10; img[7] = 8'h00;

    //            name     base      len    gap junk nwr a0        a1        c0 c1  done csum
    vecs[0] = mk("len0",  14'h0ABC, 15'd0, 0,  0,   0,  14'h0000, 14'h0000, 0, 0,  1,   32'h0);
    vecs[1] = mk("basic", 14'h0000, 15'd2, 0,  0,   2,  14'h0000, 14'h0001, 5, 10, 11,  32'h0010_00A6);
    vecs[2] = mk("gap",   14'h0000, 15'd2, 1,  0,   2,  14'h0000, 14'h0001, 8, 16, 17,  32'h0010_00A6);
    vecs[3] = mk("wrap",  14'h3FFF, 15'd2, 0,  0,   2,  14'h3FFF, 14'h0000, 5, 10, 11,  32'h0010_00A6);
    vecs[4] = mk("junk",  14'h0200, 15'd2, 0,  1,   2,  14'h0200, 14'h0201, 5, 10, 11,  32'h0010_00A6);

    rst = 1'b1; start = 1'b0; base_addr = '0; len_words = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cs", bus.sram_cs, 1'b0);
    chk("rst_web", bus.sram_web, 4'hF);
    chk("rst_a", bus.sram_a, 14'h0);
    chk("rst_di", bus.sram_di, 32'h0);
    chk("rst_ready", bus.in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hold", cpu_hold, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_hold", cpu_hold, 1'b1);
      chk("idle_web", bus.sram_web, 4'hF);
      chk("idle_ready", bus.in_ready, 1'b0);
      chk("idle_done", done, 1'b0);
    end
    $display("idle: 10 cycles after reset, hold=%b", cpu_hold);

    // Reset landing in the middle of a write cycle must release WEB without waiting for a clock
    begin_load(14'h0005, 15'd1, t0);
    feed(4, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("wrrst_web_before", bus.sram_web, 4'b0000);
    #1 rst = 1'b0;
    #1;
    chk("wrrst_web", bus.sram_web, 4'hF);
    chk("wrrst_cs", bus.sram_cs, 1'b0);
    chk("wrrst_busy", busy, 1'b0);
    chk("wrrst_hold", cpu_hold, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    $display("reset during write: web=%h hold=%b", bus.sram_web, cpu_hold);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset after 3 bytes of the second word: the partial word must never be written
    begin_load(14'h0000, 15'd2, t0);
    feed(7, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = img[7];
    #2 rst = 1'b0;
    #1;
    chk("midrst_web", bus.sram_web, 4'hF);
    chk("midrst_hold", cpu_hold, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", bus.in_ready, 1'b0);
    chk("midrst_di", bus.sram_di, 32'h0);
    chk("midrst_a", bus.sram_a, 14'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_nwrites", wr_a.size(), 1);
    if (wr_a.size() > 0) chk("midrst_wr_addr", wr_a[0], 14'h0000);
    chk("midrst_no_done", dn_cyc.size(), 0);
    chk("midrst_hold_after", cpu_hold, 1'b1);
    $display("reset mid-load: writes=%0d hold=%b", wr_a.size(), cpu_hold);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer-side counterpart for the instruction memory. The CPU only ever reads IM, and IM's write port is otherwise tied off.
- Accepts a byte stream over a valid/ready handshake and packs every 4 bytes into one little-endian 32-bit word.
- Writes each word into an SRAM_wrapper-style port: CS/OE active-high, 4-bit active-low byte WEB, 14-bit word address, 32-bit DI.
- Holds the CPU in reset until the first image load completes.

Parameters:
ADDR_W, 14, SRAM word-address width
LEN_W, 15, word-count width (ADDR_W+1, so a full 2^ADDR_W image fits)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  load request pulse; sampled only in IDLE
base_addr  input  ADDR_W  first word address; sampled with start
len_words  input  LEN_W  number of words to load; sampled with start
in_valid  input  1  byte stream valid
in_data  input  8  byte stream data
in_ready  output  1  byte stream ready
sram_cs  output  1  SRAM chip select
sram_oe  output  1  SRAM output enable
sram_web  output  4  SRAM byte write enables, active-low
sram_a  output  ADDR_W  SRAM word address
sram_di  output  32  SRAM write data
busy  output  1  load in progress
done  output  1  one-cycle completion pulse
cpu_hold  output  1  CPU reset request, active-high

Behaviour:
- Reset (rst=0, async): state=IDLE; addr, word, byte_cnt, word_cnt cleared to 0.
  - Outputs: sram_cs=0, sram_oe=0, sram_web=4'hF, sram_a=0, sram_di=0, in_ready=0, busy=0, done=0, cpu_hold=1.
- All outputs are registered or decoded from registered state only; no combinational path from in_valid/start to any output.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - start=1 and len_words!=0 -> COLLECT. Latch addr=base_addr and len=len_words; clear byte_cnt and word_cnt.
  - start=1 and len_words==0 -> DONE directly; no SRAM write occurs.
- COLLECT:
  - in_ready=1, busy=1.
  - On in_valid&&in_ready, place in_data at word[8*byte_cnt+7 : 8*byte_cnt] and increment byte_cnt. Byte 0 lands in [7:0].
  - When the 4th byte is accepted (byte_cnt==3) -> WRITE.
  - No timeout; bubbles in in_valid simply stall the FSM.
- WRITE (exactly 1 cycle):
  - in_ready=0, sram_cs=1, sram_web=4'b0000, sram_a=addr, sram_di=word.
  - Then word_cnt+1: if it equals len -> DONE; otherwise addr+1 (wraps modulo 2^ADDR_W) -> COLLECT.
- DONE (1 cycle):
  - done=1, busy=0, and cpu_hold is cleared, staying 0 until the next reset.
  - Then -> IDLE.
- Outside WRITE: sram_web=4'hF, sram_cs=0, sram_oe=0 (the loader never reads), sram_a holds addr.
- start is ignored while busy or in DONE.
- A later load after cpu_hold has dropped is allowed; cpu_hold stays 0 for it.
- Latency: with continuous in_valid, an N-word load started at cycle 0 writes word k in cycle 5k+5 and pulses done in cycle 5N+1.
- Reset mid-operation aborts immediately. No partial write is issued, because WEB returns to 4'hF asynchronously. Collected bytes are discarded and cpu_hold returns to 1.

Optional Feature:
- Macro IM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum [31:0]: the modulo-2^32 sum of all words written in the current load.
  - Cleared to 0 on accepted start and on reset; updated in the cycle after each WRITE.
  - Stable from the done pulse until the next accepted start.
- Undefined: the checksum port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle 10 cycles -> cpu_hold=1, sram_web=4'hF, in_ready=0, done=0 throughout.
- start, base_addr=0, len=2, bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 back-to-back:
  - Writes 0x00000013 @0 at cycle 5 and 0x00100093 @1 at cycle 10.
  - done pulses at cycle 11; cpu_hold=0 after it.
- Same load with in_valid toggling every other cycle -> same writes, addresses and data; done is delayed accordingly; no extra WEB pulses.
- base_addr=14'h3FFF, len=2 -> writes to 0x3FFF then 0x0000 (wrap).
- len=0 -> done pulses 1 cycle after start, zero write cycles, cpu_hold drops. A start issued during an active load is ignored.
- Assert rst after 3 bytes of the second word -> sram_web=4'hF immediately, no write to address 1, cpu_hold=1, busy=0.
- With IM_LOADER_CHECKSUM_EN: the len=2 load above -> checksum=0x001000A6 at done.
